// File: rtl/ps2_host_tx_if.sv
// ----------------------------------------------------------------------------
// ps2_host_tx_if
// Bundles the PS/2 line sense/drive signals and the command-send handshake
// of the PS/2 host transmitter.
//   ps_c_in, ps_d_in : sensed PS/2 clock / data lines
//   wr_ps2, din      : one-cycle send request and the command byte
//   ps_c_oe, ps_d_oe : open-drain pull-low enables for clock / data
//   tx_idle          : transmitter idle (gates the keyboard receiver)
//   tx_done_tick     : one-cycle pulse, transfer acknowledged by device
//   tx_err_tick      : one-cycle pulse, missing ACK or watchdog timeout
// master = the side that owns the bus lines and issues commands,
// slave  = the transmitter itself.
// ----------------------------------------------------------------------------
interface ps2_host_tx_if;
    logic       ps_c_in;
    logic       ps_d_in;
    logic       wr_ps2;
    logic [7:0] din;
    logic       ps_c_oe;
    logic       ps_d_oe;
    logic       tx_idle;
    logic       tx_done_tick;
    logic       tx_err_tick;

    modport master (
        output ps_c_in, ps_d_in, wr_ps2, din,
        input  ps_c_oe, ps_d_oe, tx_idle, tx_done_tick, tx_err_tick
    );

    modport slave (
        input  ps_c_in, ps_d_in, wr_ps2, din,
        output ps_c_oe, ps_d_oe, tx_idle, tx_done_tick, tx_err_tick
    );
endinterface

// File: rtl/ps2_host_tx.sv
// ----------------------------------------------------------------------------
// ps2_host_tx
// PS/2 host-to-device command transmitter. Inhibits the clock for
// RTS_CYCLES, issues the start bit, shifts out 8 data bits LSB first plus
// odd parity on device clock falling edges, releases for the stop bit,
// samples the device ACK and waits for the bus to be released.
// A watchdog aborts the transfer if the device stalls.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : ps2_host_tx_if.slave (line sense/drive, send handshake, status)
// ----------------------------------------------------------------------------
module ps2_host_tx #(
    parameter int RTS_CYCLES     = 5000,       // clock inhibit length, must exceed the filter depth
    parameter int TIMEOUT_CYCLES = 1_000_000   // watchdog limit from START onward
) (
    input  logic         clk,
    input  logic         reset,
    ps2_host_tx_if.slave bus
);

    localparam int RTS_W = $clog2(RTS_CYCLES + 1);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RTS, S_START, S_DATA, S_STOP, S_ACK, S_WAIT_REL
    } state_t;

    state_t           r_state, w_state_next;
    logic [7:0]       r_filter;
    logic [7:0]       w_filter_next;
    logic             r_fclk, w_fclk_next;
    logic             w_fall;
    logic             w_timeout;
    logic [RTS_W-1:0] r_rts_cnt, w_rts_cnt_next;
    logic [WD_W-1:0]  r_wdog, w_wdog_next;
    logic [3:0]       r_idx, w_idx_next;
    logic [8:0]       r_shreg, w_shreg_next;
    logic             r_done_tick, w_done_tick_next;
    logic             r_err_tick, w_err_tick_next;

    // Clock deglitch shift filter: newest sample enters at the top.
    assign w_filter_next[7] = bus.ps_c_in;
    for (genvar gi = 0; gi < 7; gi++) begin : g_filter
        assign w_filter_next[gi] = r_filter[gi+1];
    end

    // Filtered clock only changes once every stage agrees.
    assign w_fclk_next = (&w_filter_next) ? 1'b1 :
                         (~|w_filter_next) ? 1'b0 : r_fclk;
    assign w_fall      = r_fclk & ~w_fclk_next;
    assign w_timeout   = (r_wdog == WD_W'(TIMEOUT_CYCLES - 1));

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_filter    <= '1;
            r_fclk      <= 1'b1;
            r_rts_cnt   <= '0;
            r_wdog      <= '0;
            r_idx       <= '0;
            r_shreg     <= '0;
            r_done_tick <= 1'b0;
            r_err_tick  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_filter    <= w_filter_next;
            r_fclk      <= w_fclk_next;
            r_rts_cnt   <= w_rts_cnt_next;
            r_wdog      <= w_wdog_next;
            r_idx       <= w_idx_next;
            r_shreg     <= w_shreg_next;
            r_done_tick <= w_done_tick_next;
            r_err_tick  <= w_err_tick_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next     = r_state;
        w_rts_cnt_next   = r_rts_cnt;
        w_wdog_next      = '0;
        w_idx_next       = r_idx;
        w_shreg_next     = r_shreg;
        w_done_tick_next = 1'b0;
        w_err_tick_next  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.wr_ps2) begin
                    // ~^ gives 1 when din has an even count of ones -> odd total
                    w_shreg_next   = {~^bus.din, bus.din};
                    w_rts_cnt_next = '0;
                    w_idx_next     = '0;
                    w_state_next   = S_RTS;
                end
            end
            S_RTS: begin
                if (r_rts_cnt == RTS_W'(RTS_CYCLES - 1)) begin
                    w_state_next = S_START;
                end else begin
                    w_rts_cnt_next = r_rts_cnt + RTS_W'(1);
                end
            end
            default: begin
                // START..WAIT_REL are all under the watchdog
                w_wdog_next = r_wdog + WD_W'(1);
                if (w_timeout) begin
                    // timeout wins over a fall in the same cycle
                    w_wdog_next     = '0;
                    w_err_tick_next = 1'b1;
                    w_state_next    = S_IDLE;
                end else begin
                    case (r_state)
                        S_START: begin
                            if (w_fall) begin
                                w_idx_next   = '0;
                                w_state_next = S_DATA;
                            end
                        end
                        S_DATA: begin
                            if (w_fall) begin
                                w_shreg_next = {1'b0, r_shreg[8:1]};
                                w_idx_next   = r_idx + 4'd1;
                                if (r_idx == 4'd8) begin
                                    w_state_next = S_STOP;
                                end
                            end
                        end
                        S_STOP: begin
                            if (w_fall) begin
                                w_state_next = S_ACK;
                            end
                        end
                        S_ACK: begin
                            if (w_fall) begin
                                if (!bus.ps_d_in) begin
                                    w_state_next = S_WAIT_REL;
                                end else begin
                                    w_err_tick_next = 1'b1;
                                    w_state_next    = S_IDLE;
                                end
                            end
                        end
                        S_WAIT_REL: begin
                            if (r_fclk && bus.ps_d_in) begin
                                w_done_tick_next = 1'b1;
                                w_state_next     = S_IDLE;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    // Line drive and status outputs
    always_comb begin
        bus.ps_c_oe = 1'b0;
        bus.ps_d_oe = 1'b0;
        bus.tx_idle = 1'b0;
        case (r_state)
            S_IDLE:  bus.tx_idle = 1'b1;
            S_RTS:   bus.ps_c_oe = 1'b1;
            S_START: bus.ps_d_oe = 1'b1;           // start bit 0
            S_DATA:  bus.ps_d_oe = ~r_shreg[0];    // pull low for a 0 bit
            default: ;
        endcase
    end

    assign bus.tx_done_tick = r_done_tick;
    assign bus.tx_err_tick  = r_err_tick;

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
module tb_ps2_host_tx;
    localparam int RTS  = 5000;
    localparam int TMO  = 2000;
    localparam int HALF = 20;

    typedef struct {
        logic [7:0] din;
        bit         par;     // expected parity bit level on the line
        bit         ack;     // model keyboard ACKs
        int         glitch;  // pulse number whose high phase gets a 3-cycle glitch (0 = none)
        int         wrb;     // bit index during which a second wr_ps2 is issued (-1 = none)
        int         rstb;    // bit index at which reset is asserted (-1 = none)
        int         res;     // expected outcome: 1 done, 2 err, 0 none
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic kbd_clk = 1'b1;
    logic kbd_data = 1'b1;

    int checks = 0;
    int errors = 0;
    bit bit_q[$];
    int out_q[$];
    int obs_q[$];
    logic prev_tick = 1'b0;

    ps2_host_tx_if bus_if();

    assign bus_if.ps_c_in = kbd_clk & ~bus_if.ps_c_oe;
    assign bus_if.ps_d_in = kbd_data & ~bus_if.ps_d_oe;

    ps2_host_tx #(.RTS_CYCLES(RTS), .TIMEOUT_CYCLES(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Tick monitor: records every tick, checks width and exclusivity
    always @(negedge clk) begin
        if (bus_if.tx_done_tick || bus_if.tx_err_tick) begin
            check("tick_excl", int'(bus_if.tx_done_tick && bus_if.tx_err_tick), 0);
            check("tick_width", int'(prev_tick), 0);
            obs_q.push_back(bus_if.tx_done_tick ? 1 : 2);
        end
        prev_tick <= bus_if.tx_done_tick | bus_if.tx_err_tick;
    end

    task automatic send(input vec_t v);
        int n;
        int bad;
        int lvl;
        int exp_b;
        @(negedge clk);
        check("idle_before", int'(bus_if.tx_idle), 1);
        bus_if.din    = v.din;
        bus_if.wr_ps2 = 1'b1;
        for (int i = 0; i < 8; i++) bit_q.push_back(v.din[i]);
        bit_q.push_back(v.par);
        bit_q.push_back(1'b1);
        if (v.res != 0) out_q.push_back(v.res);
        @(negedge clk);
        bus_if.wr_ps2 = 1'b0;
        check("rts_latency", int'(bus_if.ps_c_oe), 1);
        n = 0;
        bad = 0;
        while (bus_if.ps_c_oe && n < RTS + 100) begin
            n++;
            if (bus_if.ps_d_oe) bad++;
            @(negedge clk);
        end
        check("rts_len", n, RTS);
        check("rts_d_released", bad, 0);
        check("start_bit_oe", int'(bus_if.ps_d_oe), 1);
        repeat (30) @(negedge clk);
        for (int k = 1; k <= 12; k++) begin
            if (k == 12 && v.ack) kbd_data = 1'b0;
            kbd_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            if (k == v.wrb + 1) begin
                bus_if.din    = ~v.din;
                bus_if.wr_ps2 = 1'b1;
                @(negedge clk);
                bus_if.wr_ps2 = 1'b0;
            end
            if (k <= 10) begin
                lvl = int'(!bus_if.ps_d_oe);
                exp_b = (bit_q.size() > 0) ? int'(bit_q.pop_front()) : -1;
                check($sformatf("din=%02h bit%0d", v.din, k - 1), lvl, exp_b);
            end
            if (k - 1 == v.rstb) begin
                reset = 1'b1;
                @(negedge clk);
                check("rst_c_oe", int'(bus_if.ps_c_oe), 0);
                check("rst_d_oe", int'(bus_if.ps_d_oe), 0);
                check("rst_idle", int'(bus_if.tx_idle), 1);
                reset   = 1'b0;
                kbd_clk = 1'b1;
                bit_q.delete();
                repeat (50) @(negedge clk);
                check("rst_no_tick", obs_q.size(), 0);
                $display("tx din=%02h aborted by reset at bit %0d", v.din, v.rstb);
                return;
            end
            kbd_clk = 1'b1;
            if (k == v.glitch) begin
                repeat (12) @(negedge clk);
                lvl = int'(!bus_if.ps_d_oe);
                kbd_clk = 1'b0;
                repeat (3) @(negedge clk);
                kbd_clk = 1'b1;
                repeat (HALF) @(negedge clk);
                check("glitch_hold", int'(!bus_if.ps_d_oe), lvl);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            if (k == 12) kbd_data = 1'b1;
        end
        n = 0;
        while (obs_q.size() == 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (20) @(negedge clk);
        check("one_tick", obs_q.size(), 1);
        if (obs_q.size() > 0 && out_q.size() > 0)
            check($sformatf("din=%02h outcome", v.din), obs_q.pop_front(), out_q.pop_front());
        obs_q.delete();
        check("idle_after", int'(bus_if.tx_idle), 1);
        $display("tx din=%02h ack=%0d expected outcome=%0d checks=%0d errors=%0d",
                 v.din, v.ack, v.res, checks, errors);
    endtask

    initial begin
        vec_t vecs[8];
        int n;
        vecs[0] = '{8'hED, 1'b1, 1'b1, 0, -1, -1, 1};
        vecs[1] = '{8'h01, 1'b0, 1'b1, 0, -1, -1, 1};
        vecs[2] = '{8'hF4, 1'b0, 1'b0, 0, -1, -1, 2};
        vecs[3] = '{8'hAA, 1'b1, 1'b1, 0,  3, -1, 1};
        vecs[4] = '{8'h3C, 1'b1, 1'b1, 2, -1, -1, 1};
        vecs[5] = '{8'h5A, 1'b1, 1'b1, 0, -1,  4, 0};
        vecs[6] = '{8'hFF, 1'b1, 1'b1, 0, -1, -1, 1};
        vecs[7] = '{8'h00, 1'b1, 1'b1, 0, -1, -1, 1};

        bus_if.wr_ps2 = 1'b0;
        bus_if.din    = 8'h00;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_idle", int'(bus_if.tx_idle), 1);
        check("reset_c_oe", int'(bus_if.ps_c_oe), 0);
        check("reset_d_oe", int'(bus_if.ps_d_oe), 0);
        check("reset_ticks", int'(bus_if.tx_done_tick | bus_if.tx_err_tick), 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 8; i++) send(vecs[i]);

        // Watchdog: device never clocks after the inhibit
        out_q.push_back(2);
        @(negedge clk);
        bus_if.din    = 8'h55;
        bus_if.wr_ps2 = 1'b1;
        @(negedge clk);
        bus_if.wr_ps2 = 1'b0;
        n = 0;
        while (bus_if.ps_c_oe && n < RTS + 100) begin
            @(negedge clk);
            n++;
        end
        check("tmo_start_bit", int'(bus_if.ps_d_oe), 1);
        n = 0;
        while (!bus_if.tx_err_tick && n < TMO + 100) begin
            @(negedge clk);
            n++;
        end
        check("tmo_cycles", n, TMO);
        check("tmo_c_oe", int'(bus_if.ps_c_oe), 0);
        check("tmo_d_oe", int'(bus_if.ps_d_oe), 0);
        repeat (5) @(negedge clk);
        check("tmo_one_tick", obs_q.size(), 1);
        if (obs_q.size() > 0 && out_q.size() > 0)
            check("tmo_outcome", obs_q.pop_front(), out_q.pop_front());
        check("tmo_idle", int'(bus_if.tx_idle), 1);
        $display("tx din=55 watchdog after %0d cycles checks=%0d errors=%0d", n, checks, errors);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 The parameter RTS_CYCLES SHALL default to 5000 and set the clock-inhibit duration in clk cycles (100 us at 50 MHz).
REQ-002 The parameter TIMEOUT_CYCLES SHALL default to 1_000_000 and set the watchdog limit in clk cycles (20 ms at 50 MHz).
REQ-003 The port clk SHALL be an input, 1 bit wide, and serve as the system clock; all logic is on its rising edge.
REQ-004 The port reset SHALL be an input, 1 bit wide, synchronous and active-high.
REQ-005 The port ps_c_in SHALL be an input, 1 bit wide, carrying the sensed PS/2 clock line.
REQ-006 The port ps_d_in SHALL be an input, 1 bit wide, carrying the sensed PS/2 data line.
REQ-007 The port wr_ps2 SHALL be an input, 1 bit wide, acting as a one-cycle command-send request.
REQ-008 The port din SHALL be an input, 8 bits wide, carrying the command byte and sampled when wr_ps2 is accepted.
REQ-009 The port ps_c_oe SHALL be an output, 1 bit wide; 1 pulls the clock line low and 0 releases it (open-drain).
REQ-010 The port ps_d_oe SHALL be an output, 1 bit wide; 1 pulls the data line low and 0 releases it.
REQ-011 The port tx_idle SHALL be an output, 1 bit wide, high while in IDLE, for gating the keyboard receiver.
REQ-012 The port tx_done_tick SHALL be an output, 1 bit wide, pulsing for one cycle when a transfer ends successfully.
REQ-013 The port tx_err_tick SHALL be an output, 1 bit wide, pulsing for one cycle on a missing ACK or a timeout.

Function
REQ-014 ps_c_in SHALL pass through an 8-stage shift filter; the filtered clock is set to 1 when all stages are 1, cleared to 0 when all stages are 0, and held otherwise.
REQ-015 A falling edge (fall) SHALL be flagged when the registered filtered clock was 1 and is now 0.
REQ-016 The states SHALL be IDLE, RTS, START, DATA, STOP, ACK, WAIT_REL.
REQ-017 In IDLE, wr_ps2=1 SHALL load the shift register with {odd_parity(din), din}, clear the counters and enter RTS; wr_ps2 in any other state SHALL be ignored.
REQ-018 In RTS, ps_c_oe=1 and ps_d_oe=0 SHALL hold for exactly RTS_CYCLES cycles, then the block enters START.
REQ-019 In START, ps_c_oe=0 and ps_d_oe=1 (start bit 0); fall SHALL enter DATA with the bit index at 0.
REQ-020 In DATA, ps_d_oe SHALL equal ~shreg[0]; on each fall the register shifts right and the index increments, covering 8 data bits LSB first plus parity (9 bits); the fall after bit index 8 enters STOP.
REQ-021 In STOP, ps_d_oe=0 (stop bit 1); fall SHALL enter ACK.
REQ-022 In ACK, at the next fall the block SHALL sample ps_d_in: 0 means ACK accepted and enters WAIT_REL; 1 means error, and the block pulses tx_err_tick and returns to IDLE.
REQ-023 In WAIT_REL, when the filtered clock and ps_d_in are both 1, the block SHALL pulse tx_done_tick and enter IDLE.
REQ-024 The watchdog SHALL count every cycle in START through WAIT_REL and clear in IDLE and RTS.
REQ-025 When the watchdog reaches TIMEOUT_CYCLES-1, the block SHALL release both lines, pulse tx_err_tick and enter IDLE; timeout takes priority over a simultaneous fall.
REQ-026 Both oe outputs SHALL be 0 in IDLE, ACK and WAIT_REL.
REQ-027 tx_done_tick and tx_err_tick SHALL be mutually exclusive, and each SHALL be high for one cycle only.
REQ-028 The parity bit SHALL make the count of ones in the 9 bits odd.
REQ-029 Latency: the first bus activity (ps_c_oe=1) SHALL occur in the cycle after wr_ps2 is accepted.

Reset
REQ-030 While reset=1, the block SHALL be in IDLE with ps_c_oe=0, ps_d_oe=0, tx_idle=1, tx_done_tick=0 and tx_err_tick=0.
REQ-031 Under reset, the filter stages SHALL be all 1s, the filtered clock 1, and all counters and the shift register 0.
REQ-032 A reset asserted mid-transfer SHALL release both lines on the next clock edge and SHALL emit no done or err tick.

Verification
REQ-033 Scenario 1: din=0xED with the model keyboard clocking and ACKing -> ps_c_oe high for 5000 cycles, data bits 1,0,1,1,0,1,1,1, then parity 1, then stop released, then one tx_done_tick.
REQ-034 Scenario 2: din=0x01 -> parity bit driven as 0 (ps_d_oe=1 during the parity bit).
REQ-035 Scenario 3: the model holds data high on the ACK clock -> one tx_err_tick, no tx_done_tick, back in IDLE.
REQ-036 Scenario 4: the model never clocks after RTS -> tx_err_tick exactly TIMEOUT_CYCLES cycles after START is entered, with both oe outputs at 0.
REQ-037 Scenario 5: wr_ps2 pulsed during DATA with a different din -> ignored, and the original byte completes unchanged.
REQ-038 Scenario 6: reset asserted at bit 4 of DATA -> both oe outputs 0 and tx_idle=1 on the next edge; a new wr_ps2 afterwards transfers correctly.
REQ-039 Glitch check: a 3-cycle low pulse on ps_c_in during DATA -> no bit advance.
